// File: rtl/text_line_buffer.sv
// text_line_buffer: one line of NUM_CHARS 5-bit letter cells with a 2-stage pixel read path.
// Define TEXT_WRAP_EN to wrap the write cursor instead of saturating when the line is full.
module text_line_buffer #(
  parameter int X_POS     = 128,
  parameter int Y_POS     = 128,
  parameter int NUM_CHARS = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [4:0]  char_in,
  input  logic        char_valid_in,
  output logic        char_ready_out,
  input  logic        clear_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  output logic [4:0]  letter_out,
  output logic [4:0]  rel_x_out,
  output logic [4:0]  rel_y_out,
  output logic        active_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out
);
  localparam int CW = $clog2(NUM_CHARS);
  localparam int LAST_I = NUM_CHARS - 1;
  localparam int XLIM_I = NUM_CHARS * 32;
  localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];
  localparam logic [CW:0] FULL = NUM_CHARS[CW:0];
  localparam logic [11:0] XLIM = XLIM_I[11:0];
  localparam logic [10:0] XP = X_POS[10:0];
  localparam logic [9:0] YP = Y_POS[9:0];
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [CW:0] cursor_q, cursor_d, cursor_inc;
  logic [CW-1:0] clr_q, clr_d, wr_idx;
  logic [4:0] mem_q [NUM_CHARS];
  logic [4:0] wr_data;
  logic wr_en, take, can_take;
  logic [10:0] rx_q, hc1_q, hc2_q;
  logic [9:0] ry_q, vc1_q, vc2_q;
  logic [4:0] letter_q, relx_q, rely_q;
  logic act_q, act;
`ifdef TEXT_WRAP_EN
  assign can_take = 1'b1;
  assign cursor_inc = cursor_q[CW-1:0] == LAST ? '0 : cursor_q + 1'b1;
`else
  assign can_take = cursor_q < FULL;
  assign cursor_inc = cursor_q + 1'b1;
`endif
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (clear_in ? CLEAR : IDLE) : (clr_q == LAST ? IDLE : CLEAR);
  always_comb begin
    char_ready_out = rst_n_in && state_q == IDLE && !clear_in && can_take;
    take = char_valid_in && char_ready_out;
    wr_en = take || state_q == CLEAR;
    wr_idx = state_q == CLEAR ? clr_q : cursor_q[CW-1:0];
    wr_data = state_q == CLEAR ? 5'd0 : char_in;
    clr_d = state_q == CLEAR ? clr_q + 1'b1 : '0;
    cursor_d = (state_q == IDLE && clear_in) ? '0 : take ? cursor_inc : cursor_q;
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      cursor_q <= '0;
      clr_q <= '0;
      for (int i = 0; i < NUM_CHARS; i++) mem_q[i] <= '0;
    end else begin
      cursor_q <= cursor_d;
      clr_q <= clr_d;
      if (wr_en) mem_q[wr_idx] <= wr_data;
    end
  // Offsets wrap unsigned, so pixels left of or above the origin fall outside the box.
  assign act = {1'b0, rx_q} < XLIM && ry_q < 10'd32;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      rx_q <= '0;
      ry_q <= '0;
      hc1_q <= '0;
      vc1_q <= '0;
      hc2_q <= '0;
      vc2_q <= '0;
      letter_q <= '0;
      relx_q <= '0;
      rely_q <= '0;
      act_q <= 1'b0;
    end else begin
      rx_q <= hcount_in - XP;
      ry_q <= vcount_in - YP;
      hc1_q <= hcount_in;
      vc1_q <= vcount_in;
      hc2_q <= hc1_q;
      vc2_q <= vc1_q;
      letter_q <= act ? mem_q[rx_q[5 +: CW]] : 5'd0;
      relx_q <= act ? rx_q[4:0] : 5'd0;
      rely_q <= act ? ry_q[4:0] : 5'd0;
      act_q <= act;
    end
  assign letter_out = letter_q;
  assign rel_x_out = relx_q;
  assign rel_y_out = rely_q;
  assign active_out = act_q;
  assign hcount_out = hc2_q;
  assign vcount_out = vc2_q;
endmodule

// File: tb/tb_text_line_buffer.sv
// tb_text_line_buffer: directed stimulus for text_line_buffer with a per-cycle reference model.
module tb_text_line_buffer;
  localparam int NC = 16;
  localparam int XP = 128;
  localparam int YP = 128;
`ifdef TEXT_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [4:0] ch = '0;
  logic valid = 1'b0;
  logic clear = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0] vcount = '0;
  logic ready, active;
  logic [4:0] letter, rel_x, rel_y;
  logic [10:0] hc_o;
  logic [9:0] vc_o;
  int n_cmp = 0;
  int n_bad = 0;
  int ent[NC];
  int cur = 0, clr_left = 0, p_rx = 0, p_ry = 0, p_h = 0, p_v = 0;
  int e_let = 0, e_rx = 0, e_ry = 0, e_act = 0, e_h = 0, e_v = 0;
  int a;
  logic rdy;
  always #5 clk = ~clk;
  text_line_buffer dut (
    .clk_in(clk), .rst_n_in(rst_n), .char_in(ch), .char_valid_in(valid),
    .char_ready_out(ready), .clear_in(clear), .hcount_in(hcount), .vcount_in(vcount),
    .letter_out(letter), .rel_x_out(rel_x), .rel_y_out(rel_y), .active_out(active),
    .hcount_out(hc_o), .vcount_out(vc_o)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic exp_ready();
    return rst_n && clr_left == 0 && !clear && (WRAP || cur < NC);
  endfunction
  always @(negedge rst_n) begin
    foreach (ent[i]) ent[i] = 0;
    cur = 0; clr_left = 0;
    p_rx = 0; p_ry = 0; p_h = 0; p_v = 0;
    e_let = 0; e_rx = 0; e_ry = 0; e_act = 0; e_h = 0; e_v = 0;
  end
  // Mid-cycle: check last edge's outputs and current ready, then advance the model to the next edge.
  always @(negedge clk) begin
    rdy = exp_ready();
    chk("letter_out", letter, e_let);
    chk("rel_x_out", rel_x, e_rx);
    chk("rel_y_out", rel_y, e_ry);
    chk("active_out", active, e_act);
    chk("hcount_out", hc_o, e_h);
    chk("vcount_out", vc_o, e_v);
    chk("char_ready_out", ready, rdy);
    if (rst_n) begin
      a = (p_rx < NC * 32 && p_ry < 32) ? 1 : 0;
      e_act = a;
      e_let = a != 0 ? ent[(p_rx / 32) % NC] : 0;
      e_rx = a != 0 ? p_rx % 32 : 0;
      e_ry = a != 0 ? p_ry % 32 : 0;
      e_h = p_h;
      e_v = p_v;
      p_rx = (int'(hcount) - XP) & 2047;
      p_ry = (int'(vcount) - YP) & 1023;
      p_h = int'(hcount);
      p_v = int'(vcount);
      if (clr_left > 0) begin
        ent[NC - clr_left] = 0;
        clr_left--;
      end else if (clear) begin
        clr_left = NC;
        cur = 0;
      end else if (valid && rdy) begin
        ent[cur] = int'(ch);
        cur = WRAP ? (cur + 1) % NC : cur + 1;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set(input logic v, input logic [4:0] c, input logic cl, input int h, input int vv);
    valid = v; ch = c; clear = cl;
    hcount = h[10:0];
    vcount = vv[9:0];
  endtask
  task automatic rd(input int h, input int v);
    set(1'b0, 5'd0, 1'b0, h, v);
    tick();
    tick();
  endtask
  initial begin
    #1 rst_n = 1'b0;
    repeat (2) tick();
    chk("reset ready", ready, 0);
    chk("reset active", active, 0);
    chk("reset letter", letter, 0);
    chk("reset hcount_out", hc_o, 0);
    rst_n = 1'b1;
    #1 chk("ready after release", ready, 1);
    for (int i = 1; i <= 3; i++) begin
      set(1'b1, 5'(i), 1'b0, 0, 0);
      #1 chk("ready while writing", ready, 1);
      tick();
    end
    set(1'b0, 5'd0, 1'b0, 0, 0);
    #1 chk("ready after 3 writes", ready, 1);
    rd(161, 133);
    chk("cell1 letter", letter, 2);
    chk("cell1 rel_x", rel_x, 1);
    chk("cell1 rel_y", rel_y, 5);
    chk("cell1 active", active, 1);
    chk("cell1 hcount_out", hc_o, 161);
    chk("cell1 vcount_out", vc_o, 133);
    rd(128, 128);
    chk("cell0 letter", letter, 1);
    rd(128 + 64 + 31, 128 + 31);
    chk("cell2 corner letter", letter, 3);
    chk("cell2 corner rel_x", rel_x, 31);
    chk("cell2 corner rel_y", rel_y, 31);
    rd(127, 130);
    chk("left of origin active", active, 0);
    chk("left of origin letter", letter, 0);
    rd(130, 160);
    chk("below line active", active, 0);
    chk("below line letter", letter, 0);
    rd(128 + 511, 128);
    chk("last column active", active, 1);
    chk("last column rel_x", rel_x, 31);
    rd(128 + 512, 128);
    chk("past last column active", active, 0);
    for (int i = 4; i <= 16; i++) begin
      set(1'b1, 5'(i), 1'b0, 128 + 32 * (i % 16), 140);
      tick();
    end
    set(1'b0, 5'd0, 1'b0, 0, 0);
    #1 chk("ready when full", ready, WRAP);
    set(1'b1, 5'd31, 1'b0, 0, 0);
    tick();
    rd(128, 128);
    chk("entry0 after 17th", letter, WRAP ? 31 : 1);
    rd(128 + 15 * 32, 128);
    chk("entry15", letter, 16);
    set(1'b1, 5'd7, 1'b1, 128, 128);
    #1 chk("ready with clear", ready, 0);
    tick();
    for (int i = 0; i < NC; i++) begin
      set(1'b1, 5'd9, i == 5, 128 + 32 * i, 129);
      #1 chk("ready during clear", ready, 0);
      tick();
    end
    set(1'b1, 5'd9, 1'b0, 0, 0);
    #1 chk("ready after clear", ready, 1);
    tick();
    rd(128, 128);
    chk("entry0 after clear", letter, 9);
    rd(128 + 32, 128);
    chk("entry1 cleared", letter, 0);
    chk("entry1 cleared active", active, 1);
    rd(128 + 15 * 32, 128);
    chk("entry15 cleared", letter, 0);
    set(1'b1, 5'd4, 1'b0, 0, 0);
    tick();
    set(1'b1, 5'd6, 1'b0, 0, 0);
    tick();
    rd(128 + 35, 135);
    chk("pre-reset letter", letter, 4);
    chk("pre-reset hcount_out", hc_o, 163);
    set(1'b0, 5'd0, 1'b1, 128 + 35, 135);
    tick();
    set(1'b0, 5'd0, 1'b0, 128 + 35, 135);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async reset letter", letter, 0);
    chk("async reset rel_x", rel_x, 0);
    chk("async reset rel_y", rel_y, 0);
    chk("async reset active", active, 0);
    chk("async reset hcount_out", hc_o, 0);
    chk("async reset ready", ready, 0);
    tick();
    rst_n = 1'b1;
    #1 chk("ready after abort", ready, 1);
    rd(128 + 64, 128);
    chk("entry2 blank after reset", letter, 0);
    chk("entry2 active after reset", active, 1);
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/text_line_buffer.md
TEXT_LINE_BUFFER -- requirements
Module: text_line_buffer

Interface
REQ-001 SHALL have parameter X_POS, default 128: hcount of left edge of the text line.
REQ-002 SHALL have parameter Y_POS, default 128: vcount of top edge of the text line.
REQ-003 SHALL have parameter NUM_CHARS, default 16: character cells in the line (power of two, 2..32).
REQ-004 SHALL have port clk_in  input  1: sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n_in  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port char_in  input  5: letter code to append (0 = blank).
REQ-007 SHALL have port char_valid_in  input  1: char_in valid this cycle.
REQ-008 SHALL have port char_ready_out  output  1: buffer can accept a character this cycle.
REQ-009 SHALL have port clear_in  input  1: single-cycle pulse requesting a blank line.
REQ-010 SHALL have port hcount_in  input  11: current pixel column.
REQ-011 SHALL have port vcount_in  input  10: current pixel row.
REQ-012 SHALL have port letter_out  output  5: letter code for the current pixel's cell, to the glyph renderer.
REQ-013 SHALL have port rel_x_out  output  5, and rel_y_out  output  5: pixel offset inside the 32x32 cell.
REQ-014 SHALL have port active_out  output  1: pixel lies inside the text line.
REQ-015 SHALL have ports hcount_out  output  11 and vcount_out  output  10: hcount_in/vcount_in delayed to align with letter_out.

Function
REQ-016 SHALL hold NUM_CHARS x 5-bit entries plus a write cursor of width clog2(NUM_CHARS)+1.
REQ-017 SHALL run FSM states IDLE and CLEAR; reset state IDLE.
REQ-018 IDLE: a char_valid_in && char_ready_out handshake SHALL write char_in to entry[cursor] and increment cursor, same edge.
REQ-019 char_ready_out SHALL be combinational: 1 only in IDLE, with clear_in low, and cursor < NUM_CHARS (see REQ-030).
REQ-020 IDLE with clear_in high SHALL enter CLEAR, set cursor to 0, and drop any concurrent char (not written, ready low).
REQ-021 CLEAR SHALL zero one entry per cycle, index 0 upward, returning to IDLE the cycle after entry NUM_CHARS-1 is zeroed (NUM_CHARS cycles in CLEAR).
REQ-022 clear_in during CLEAR SHALL be ignored (no restart).
REQ-023 Read path SHALL be 2-cycle pipelined: stage 1 registers rx = hcount_in - X_POS (11-bit wrap) and ry = vcount_in - Y_POS (10-bit wrap); stage 2 registers outputs.
REQ-024 active_out SHALL be 1 iff rx < NUM_CHARS*32 and ry < 32, unsigned (pixels left of/above origin wrap large and are inactive).
REQ-025 When active, letter_out SHALL equal entry[rx>>5] as of stage 2, rel_x_out = rx[4:0], rel_y_out = ry[4:0]; when inactive all three SHALL be 0.
REQ-026 A write and a read of the same entry in one cycle SHALL return the old value.

Reset
REQ-027 rst_n_in low SHALL immediately force: state IDLE, cursor 0, all entries 0, all pipeline registers and outputs 0, char_ready_out 0 while reset is low.
REQ-028 Reset mid-CLEAR SHALL abort the sweep; buffer is fully blank via REQ-027.
REQ-029 First handshake SHALL be possible on the first rising edge after rst_n_in rises.

Configuration
REQ-030 Macro TEXT_WRAP_EN defined: cursor SHALL wrap NUM_CHARS-1 -> 0 on write, ready never low due to fullness, oldest entries overwritten; undefined: cursor saturates at NUM_CHARS and char_ready_out stays 0 until a clear.

Verification
REQ-031 Reset, then write codes 1,2,3 -> entries 0..2 = 1,2,3; cursor 3; ready stays 1.
REQ-032 hcount_in=128+33, vcount_in=128+5, entry1=2 -> two cycles later letter_out=2, rel_x_out=1, rel_y_out=5, active_out=1, hcount_out=161.
REQ-033 hcount_in=127 or vcount_in=160 -> active_out=0, letter_out=0 two cycles later.
REQ-034 Write 16 chars, no TEXT_WRAP_EN -> ready=0 after 16th; 17th char not stored; with TEXT_WRAP_EN 17th overwrites entry 0.
REQ-035 clear_in together with valid char 7 -> char dropped, ready=0 for 16 cycles, all entries 0, then ready=1 and next write lands in entry 0.
REQ-036 Assert rst_n_in low at cycle 5 of CLEAR, asynchronous to clk -> outputs 0 immediately, IDLE with ready=1 after release.
